alarm_clock: RTL and testbench
==============================

Name: alarm_clock

Overview:
12-hour alarm clock core. Keeps time as hours, minutes, seconds and AM/PM, advanced by a 1 Hz tick clock, and holds a programmable alarm time. Raises a sticky Alarm flag when the enabled alarm time is reached. It sits downstream of the system clock generator, which supplies the 1-second clock.

Parameters:
- TICKS_PER_SEC, 1: number of Clock_1Sec rising edges per one-second advance. The internal prescaler counts 0..TICKS_PER_SEC-1. A value of 1 means every edge advances time.

Ports:
- Clock_1Sec  in  1  timebase clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-low reset
- LoadTime  in  1  load current time from SetHours/SetMins/SetSecs/Set_AM_PM
- LoadAlm  in  1  load alarm time from AlarmHoursIn/AlarmMinsIn/Alarm_AM_PM_In
- AlarmEnable  in  1  1 = alarm armed; 0 = alarm disarmed and Alarm cleared
- Set_AM_PM  in  1  AM/PM value for a time load (0 = AM, 1 = PM)
- Alarm_AM_PM_In  in  1  AM/PM value for an alarm load
- SetSecs  in  6  seconds value for a time load
- SetMins  in  6  minutes value for a time load
- AlarmMinsIn  in  6  alarm minutes
- SetHours  in  4  hours value for a time load
- AlarmHoursIn  in  4  alarm hours
- Control  in  1  run enable; 1 = time advances, 0 = time frozen (loads still act)
- AM_PM  out  1  current AM/PM (0 = AM, 1 = PM)
- Alarm  out  1  alarm flag, registered, sticky
- Secs_C  out  6  current seconds, 0..59
- Mins_C  out  6  current minutes, 0..59
- Hours_C  out  4  current hours, 1..12

Behaviour:
- Reset (Reset=0, asynchronous):
  - Hours_C=12, Mins_C=0, Secs_C=0, AM_PM=0 (12:00:00 AM).
  - Alarm registers = 12:00 AM.
  - Alarm=0; prescaler=0.
  - All state holds while Reset=0.
- Time load: on an edge with LoadTime=1, the time registers take the Set* values and the prescaler clears.
  - LoadTime has priority over counting on that edge.
  - Sanitizing: SetSecs>59 loads 0; SetMins>59 loads 0; SetHours=0 or >12 loads 12.
- Alarm load: on an edge with LoadAlm=1, the alarm registers load with the same sanitizing.
  - Independent of LoadTime; both may occur on the same edge.
- Counting: on an edge with Control=1, LoadTime=0 and prescaler==TICKS_PER_SEC-1, time advances one second; otherwise the prescaler increments.
  - Secs 59->0 carries into minutes.
  - Mins 59->0 carries into hours.
  - Hours 11->12 toggles AM_PM (11:59:59 AM -> 12:00:00 PM; 11:59:59 PM -> 12:00:00 AM).
  - Hours 12->1 leaves AM_PM unchanged.
  - Control=0: time and prescaler hold.
- Alarm:
  - Match = AlarmEnable=1 AND Hours_C==alarm hours AND Mins_C==alarm minutes AND AM_PM==alarm AM/PM AND Secs_C==0, evaluated on registered values.
  - Alarm is set on the edge where Match is true, so it rises one clock after the matching time is displayed. This applies whether the match was reached by counting or by a load.
  - Once set, Alarm stays 1 through later time changes until AlarmEnable=0, which clears it on the next edge, or until Reset.
  - AlarmEnable=0 and Match on the same edge: Alarm=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: Reset=0 -> Hours_C=12, Mins_C=0, Secs_C=0, AM_PM=0, Alarm=0; release with Control=1 -> Secs_C=1 after the first edge.
- Load and rollover: load 11:59:58 AM, Control=1 -> after 2 edges 12:00:00, AM_PM=1; load 12:59:59 PM -> after 1 edge 1:00:00 PM.
- Midnight wrap and sanitizing: load 11:59:59 PM -> after 1 edge 12:00:00 AM; load SetHours=0, SetMins=63, SetSecs=60 -> 12:00:00.
- Alarm fire: alarm 7:30 AM, AlarmEnable=1, load 7:29:59 AM -> Secs_C=0 at 7:30 on edge 1; Alarm=1 on edge 2 and still 1 at 7:31; drop AlarmEnable -> Alarm=0 on the next edge.
- Alarm gated: same setup with AlarmEnable=0, or alarm set to 7:30 PM -> Alarm stays 0 through 7:30 AM.
- Freeze and priority: Control=0 for 5 edges -> time unchanged; LoadTime=1 and LoadAlm=1 on the same edge -> both register sets updated.

Source files
------------

// File: rtl/alarm_clock.sv
// alarm_clock: 12-hour alarm clock core.
// Keeps hours/minutes/seconds/AM-PM, advanced once per TICKS_PER_SEC rising
// edges of Clock_1Sec while Control=1, and raises a sticky Alarm flag when
// the armed alarm time (hh:mm:00, AM/PM) is reached.
//
// Ports:
//   Clock_1Sec      in   timebase clock, rising edge
//   Reset           in   asynchronous active-low reset
//   LoadTime        in   load time from SetHours/SetMins/SetSecs/Set_AM_PM
//   LoadAlm         in   load alarm from AlarmHoursIn/AlarmMinsIn/Alarm_AM_PM_In
//   AlarmEnable     in   1 = alarm armed, 0 = disarmed and Alarm cleared
//   Set_AM_PM       in   AM/PM for a time load (1 = PM)
//   Alarm_AM_PM_In  in   AM/PM for an alarm load
//   SetSecs/SetMins in   [5:0] time load values
//   SetHours        in   [3:0] time load hours
//   AlarmMinsIn     in   [5:0] alarm minutes
//   AlarmHoursIn    in   [3:0] alarm hours
//   Control         in   run enable
//   AM_PM           out  current AM/PM
//   Alarm           out  sticky alarm flag
//   Secs_C/Mins_C   out  [5:0] current seconds/minutes
//   Hours_C         out  [3:0] current hours, 1..12
module alarm_clock #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       Clock_1Sec,
    input  logic       Reset,
    input  logic       LoadTime,
    input  logic       LoadAlm,
    input  logic       AlarmEnable,
    input  logic       Set_AM_PM,
    input  logic       Alarm_AM_PM_In,
    input  logic [5:0] SetSecs,
    input  logic [5:0] SetMins,
    input  logic [5:0] AlarmMinsIn,
    input  logic [3:0] SetHours,
    input  logic [3:0] AlarmHoursIn,
    input  logic       Control,
    output logic       AM_PM,
    output logic       Alarm,
    output logic [5:0] Secs_C,
    output logic [5:0] Mins_C,
    output logic [3:0] Hours_C
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] prescale;
    logic [3:0]    alm_hours;
    logic [5:0]    alm_mins;
    logic          alm_pm;
    logic          match;

    // Out-of-range loads are forced to a legal value instead of being rejected.
    function automatic logic [5:0] clamp_60(input logic [5:0] v);
        return (v > 6'd59) ? 6'd0 : v;
    endfunction

    function automatic logic [3:0] clamp_hr(input logic [3:0] v);
        return ((v == 4'd0) || (v > 4'd12)) ? 4'd12 : v;
    endfunction

    // Evaluated on registered state only, so a load that lands on the alarm
    // time is seen one edge later, exactly like a counted arrival.
    assign match = AlarmEnable && (Hours_C == alm_hours) && (Mins_C == alm_mins)
                   && (AM_PM == alm_pm) && (Secs_C == 6'd0);

    always_ff @(posedge Clock_1Sec or negedge Reset) begin
        if (!Reset) begin
            Hours_C  <= 4'd12;
            Mins_C   <= 6'd0;
            Secs_C   <= 6'd0;
            AM_PM    <= 1'b0;
            prescale <= '0;
        end else if (LoadTime) begin
            Hours_C  <= clamp_hr(SetHours);
            Mins_C   <= clamp_60(SetMins);
            Secs_C   <= clamp_60(SetSecs);
            AM_PM    <= Set_AM_PM;
            prescale <= '0;
        end else if (Control) begin
            if (prescale == PRE_LAST) begin
                prescale <= '0;
                if (Secs_C == 6'd59) begin
                    Secs_C <= 6'd0;
                    if (Mins_C == 6'd59) begin
                        Mins_C <= 6'd0;
                        if (Hours_C == 4'd12) begin
                            Hours_C <= 4'd1;
                        end else begin
                            Hours_C <= Hours_C + 4'd1;
                        end
                        // Half-day changes when the display reaches 12, not 1.
                        if (Hours_C == 4'd11) begin
                            AM_PM <= ~AM_PM;
                        end
                    end else begin
                        Mins_C <= Mins_C + 6'd1;
                    end
                end else begin
                    Secs_C <= Secs_C + 6'd1;
                end
            end else begin
                prescale <= prescale + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock_1Sec or negedge Reset) begin
        if (!Reset) begin
            alm_hours <= 4'd12;
            alm_mins  <= 6'd0;
            alm_pm    <= 1'b0;
        end else if (LoadAlm) begin
            alm_hours <= clamp_hr(AlarmHoursIn);
            alm_mins  <= clamp_60(AlarmMinsIn);
            alm_pm    <= Alarm_AM_PM_In;
        end
    end

    always_ff @(posedge Clock_1Sec or negedge Reset) begin
        if (!Reset) begin
            Alarm <= 1'b0;
        end else if (!AlarmEnable) begin
            Alarm <= 1'b0;
        end else if (match) begin
            Alarm <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alarm_clock.sv
// tb_alarm_clock: directed plus random stimulus for alarm_clock, checked
// every edge against a model that keeps time as seconds-of-day (0..86399).
module tb_alarm_clock;

    localparam int TPS = 1;

    logic       clk = 1'b0;
    logic       Reset, LoadTime, LoadAlm, AlarmEnable, Set_AM_PM, Alarm_AM_PM_In, Control;
    logic [5:0] SetSecs, SetMins, AlarmMinsIn;
    logic [3:0] SetHours, AlarmHoursIn;
    logic       AM_PM, Alarm;
    logic [5:0] Secs_C, Mins_C;
    logic [3:0] Hours_C;

    int total = 0;
    int bad   = 0;

    // model state
    int m_t;      // seconds since midnight
    int m_alm;    // alarm as minutes since midnight
    int m_pre;
    bit m_flag;

    always #5 clk = ~clk;

    alarm_clock #(.TICKS_PER_SEC(TPS)) dut (
        .Clock_1Sec(clk), .Reset(Reset), .LoadTime(LoadTime), .LoadAlm(LoadAlm),
        .AlarmEnable(AlarmEnable), .Set_AM_PM(Set_AM_PM), .Alarm_AM_PM_In(Alarm_AM_PM_In),
        .SetSecs(SetSecs), .SetMins(SetMins), .AlarmMinsIn(AlarmMinsIn),
        .SetHours(SetHours), .AlarmHoursIn(AlarmHoursIn), .Control(Control),
        .AM_PM(AM_PM), .Alarm(Alarm), .Secs_C(Secs_C), .Mins_C(Mins_C), .Hours_C(Hours_C)
    );

    // 12-hour clock reading -> seconds since midnight, with load sanitizing
    function automatic int to_sec(int h, int m, int s, bit pm);
        int hh, mm, ss;
        hh = (h == 0 || h > 12) ? 12 : h;
        mm = (m > 59) ? 0 : m;
        ss = (s > 59) ? 0 : s;
        return ((hh % 12) + (pm ? 12 : 0)) * 3600 + mm * 60 + ss;
    endfunction

    function automatic int disp_hour(int t);
        int h;
        h = (t / 3600) % 12;
        return (h == 0) ? 12 : h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_hours"}, 32'(Hours_C), 32'(disp_hour(m_t)));
        chk({tag, "_mins"},  32'(Mins_C),  32'((m_t / 60) % 60));
        chk({tag, "_secs"},  32'(Secs_C),  32'(m_t % 60));
        chk({tag, "_ampm"},  32'(AM_PM),   32'(m_t >= 43200));
        chk({tag, "_alarm"}, 32'(Alarm),   32'(m_flag));
    endtask

    task automatic model_reset();
        m_t = 0; m_alm = 0; m_pre = 0; m_flag = 0;
    endtask

    // One clock edge: advance the model from current inputs, then compare.
    task automatic tick(input string tag);
        bit hit;
        hit = AlarmEnable && (m_t % 60 == 0) && (m_t / 60 == m_alm);
        if (LoadTime) begin
            m_t   = to_sec(SetHours, SetMins, SetSecs, Set_AM_PM);
            m_pre = 0;
        end else if (Control) begin
            if (m_pre == TPS - 1) begin
                m_t   = (m_t + 1) % 86400;
                m_pre = 0;
            end else begin
                m_pre++;
            end
        end
        if (LoadAlm) m_alm = to_sec(AlarmHoursIn, AlarmMinsIn, 0, Alarm_AM_PM_In) / 60;
        m_flag = AlarmEnable ? (m_flag | hit) : 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_time(input int h, input int m, input int s, input bit pm);
        LoadTime = 1; SetHours = 4'(h); SetMins = 6'(m); SetSecs = 6'(s); Set_AM_PM = pm;
    endtask

    task automatic set_alarm(input int h, input int m, input bit pm);
        LoadAlm = 1; AlarmHoursIn = 4'(h); AlarmMinsIn = 6'(m); Alarm_AM_PM_In = pm;
    endtask

    task automatic idle();
        LoadTime = 0; LoadAlm = 0;
    endtask

    initial begin
        Reset = 1; LoadTime = 0; LoadAlm = 0; AlarmEnable = 0; Control = 0;
        Set_AM_PM = 0; Alarm_AM_PM_In = 0; SetSecs = 0; SetMins = 0; AlarmMinsIn = 0;
        SetHours = 0; AlarmHoursIn = 0;

        // reset: asynchronous, holds across edges
        #2;
        Reset = 0;
        model_reset();
        #1;
        check_all("reset_async");
        Control = 1;
        @(posedge clk); #1;
        check_all("reset_hold");
        Reset = 1;
        tick("reset_release");
        chk("first_sec", 32'(Secs_C), 32'd1);

        // 11:59:58 AM -> 12:00:00 PM
        set_time(11, 59, 58, 0); tick("load_am");
        idle(); tick("noon_a"); tick("noon_b");
        chk("noon_hours", 32'(Hours_C), 32'd12);
        chk("noon_pm", 32'(AM_PM), 32'd1);

        // 12:59:59 PM -> 1:00:00 PM
        set_time(12, 59, 59, 1); tick("load_1259");
        idle(); tick("one_pm");
        chk("one_pm_hours", 32'(Hours_C), 32'd1);
        chk("one_pm_pm", 32'(AM_PM), 32'd1);

        // midnight wrap
        set_time(11, 59, 59, 1); tick("load_pm");
        idle(); tick("midnight");
        chk("midnight_am", 32'(AM_PM), 32'd0);

        // sanitizing
        set_time(0, 63, 60, 0); tick("sanitize");
        chk("sanitize_hours", 32'(Hours_C), 32'd12);
        set_time(13, 5, 7, 0); tick("sanitize13");
        idle();

        // alarm fire: loads with alarm disarmed, then arm
        AlarmEnable = 0;
        set_alarm(7, 30, 0); set_time(7, 29, 59, 0); tick("alm_load");
        idle(); AlarmEnable = 1;
        tick("alm_edge1");
        chk("alm_edge1_flag", 32'(Alarm), 32'd0);
        tick("alm_edge2");
        chk("alm_edge2_flag", 32'(Alarm), 32'd1);
        for (int i = 0; i < 60; i++) tick("alm_sticky");
        chk("alm_731_mins", 32'(Mins_C), 32'd31);
        chk("alm_731_flag", 32'(Alarm), 32'd1);
        AlarmEnable = 0; tick("alm_clear");
        chk("alm_clear_flag", 32'(Alarm), 32'd0);

        // gated: disarmed, then wrong half-day
        set_time(7, 29, 59, 0); tick("gate_load");
        idle();
        for (int i = 0; i < 3; i++) tick("gate_off");
        set_alarm(7, 30, 1); set_time(7, 29, 59, 0); tick("gate_pm_load");
        idle(); AlarmEnable = 1;
        for (int i = 0; i < 3; i++) tick("gate_pm");
        chk("gate_pm_flag", 32'(Alarm), 32'd0);

        // freeze, then simultaneous loads
        Control = 0;
        for (int i = 0; i < 5; i++) tick("freeze");
        chk("freeze_secs", 32'(Secs_C), 32'd2);
        AlarmEnable = 0;
        set_time(3, 14, 59, 1); set_alarm(3, 15, 1); tick("dual_load");
        idle(); Control = 1; AlarmEnable = 1;
        tick("dual_a"); tick("dual_b");
        chk("dual_flag", 32'(Alarm), 32'd1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int r, nt;
            idle();
            r = $urandom_range(0, 99);
            Control = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) AlarmEnable = ~AlarmEnable;
            if (r < 4) begin
                set_time($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63),
                         1'($urandom_range(0, 1)));
            end else if (r < 8) begin
                set_time($urandom_range(1, 12), $urandom_range(0, 59), 57, 1'($urandom_range(0, 1)));
            end
            if (r >= 90) begin
                nt = (m_t + 60) % 86400;
                set_alarm(disp_hour(nt), (nt / 60) % 60, nt >= 43200);
            end else if (r == 89) begin
                set_alarm($urandom_range(0, 15), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
            end
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
